// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_seq execute-stage ALU.
//   - opcode encodings of the ALU control field
//   - bit positions inside the 5-bit flags register
//   - FSM state type used by the alu_seq top
package alu_pkg;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_LW_1 = 5'd1;
  localparam logic [4:0] OP_LW_2 = 5'd2;
  localparam logic [4:0] OP_LW_3 = 5'd3;
  localparam logic [4:0] OP_SW_1 = 5'd4;
  localparam logic [4:0] OP_SW_2 = 5'd5;
  localparam logic [4:0] OP_MOV  = 5'd6;
  localparam logic [4:0] OP_ADD  = 5'd7;
  localparam logic [4:0] OP_SUB  = 5'd8;
  localparam logic [4:0] OP_MUL  = 5'd9;
  localparam logic [4:0] OP_DIV  = 5'd10;
  localparam logic [4:0] OP_AND  = 5'd11;
  localparam logic [4:0] OP_OR   = 5'd12;
  localparam logic [4:0] OP_NOT  = 5'd13;
  localparam logic [4:0] OP_SHL  = 5'd14;
  localparam logic [4:0] OP_SHR  = 5'd15;
  localparam logic [4:0] OP_CMP  = 5'd16;
  localparam logic [4:0] OP_JR   = 5'd17;
  localparam logic [4:0] OP_RET  = 5'd18;
  localparam logic [4:0] OP_JPC  = 5'd19;
  localparam logic [4:0] OP_CALL = 5'd20;
  localparam logic [4:0] OP_BRFL = 5'd21;

  localparam int FL_OVF   = 0;
  localparam int FL_ABOVE = 1;
  localparam int FL_BELOW = 2;
  localparam int FL_EQUAL = 3;
  localparam int FL_ERROR = 4;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: shared iterative multiply / divide datapath.
//   start  : load operands and begin (ignored while busy)
//   is_div : present only with ALU_SEQ_DIV_EN; selects divide for this start
//   a, b   : signed operands, sampled on start
//   done   : high in the final busy cycle; result/ovf are valid then
//   result : low WIDTH bits of the product, or the signed quotient
//   ovf    : product high half is not the sign extension of the low half
// Multiply: WIDTH shift-add steps, the last one done in the done cycle.
// Divide (ALU_SEQ_DIV_EN): WIDTH restoring steps on magnitudes, then one
// cycle that applies the quotient sign. The divisor must be non-zero.
module alu_seq_muldiv import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef ALU_SEQ_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic               busy;
  logic [CW-1:0]      cnt;
  // acc: product accumulator, or {remainder, dividend/quotient} when dividing
  logic [2*WIDTH-1:0] acc, mcand, addend, acc_nx;
  logic [WIDTH-1:0]   mplier;
  logic               last_mul;

  assign last_mul = (cnt == CW'(WIDTH - 1));

  // Two's-complement multiplier: the MSB of b carries negative weight.
  always_comb begin
    addend = '0;
    if (mplier[0]) addend = last_mul ? -mcand : mcand;
    acc_nx = acc + addend;
  end

`ifdef ALU_SEQ_DIV_EN
  logic             div_q, neg_q;
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_nx, quo_nx;

  always_comb begin
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = rem_sh - {1'b0, mcand[WIDTH-1:0]};
    rem_nx = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nx = {acc[WIDTH-2:0], ~diff[WIDTH]};
  end

  assign done   = busy & (div_q ? (cnt == CW'(WIDTH)) : last_mul);
  assign result = div_q ? (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : acc_nx[WIDTH-1:0];
  assign ovf    = ~div_q & (acc_nx[2*WIDTH-1:WIDTH] != {WIDTH{acc_nx[WIDTH-1]}});
`else
  assign done   = busy & last_mul;
  assign result = acc_nx[WIDTH-1:0];
  assign ovf    = (acc_nx[2*WIDTH-1:WIDTH] != {WIDTH{acc_nx[WIDTH-1]}});
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
`endif
    end else if (start && !busy) begin
      busy <= 1'b1;
      cnt  <= '0;
`ifdef ALU_SEQ_DIV_EN
      div_q <= is_div;
      neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      if (is_div) begin
        // magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned
        acc   <= {{WIDTH{1'b0}}, (a[WIDTH-1] ? -a : a)};
        mcand <= {{WIDTH{1'b0}}, (b[WIDTH-1] ? -b : b)};
      end else
`endif
      begin
        acc    <= '0;
        mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
        mplier <= b;
      end
    end else if (busy) begin
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      if (div_q) begin
        if (cnt != CW'(WIDTH)) acc <= {rem_nx, quo_nx};
      end else
`endif
      begin
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with iterative MUL/DIV.
//   clk, rst_n (sync, active-low)
//   in_valid/in_ready, alu_op, data1, data2, pc : operation request
//   out_valid/out_ready, alu_result, branch_target, zero : result
//   flags : [0] overflow [1] above [2] below [3] equal [4] error, kept
//           from the last ADD/SUB/MUL/DIV/CMP/undefined op
// Build option: ALU_SEQ_DIV_EN enables the iterative divider; without it
// DIV completes in one cycle with result 0, zero=1 and error set.
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          alu_op,
  input  logic [WIDTH-1:0]    data1,
  input  logic [WIDTH-1:0]    data2,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    alu_result,
  output logic [WIDTH-1:0]    branch_target,
  output logic                zero,
  output logic [4:0]          flags
);
  state_t           state, state_nx;
  logic             accept, multi, go_mul;
  logic [WIDTH-1:0] sc_res, sc_tgt, sum, dif;
  logic             sc_zero, ovf;
  logic [4:0]       sc_fl;
  logic             md_start, md_done, md_ovf;
  logic [WIDTH-1:0] md_res;
`ifdef ALU_SEQ_DIV_EN
  logic             go_div;
`endif

  assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == S_DONE);
  assign md_start  = accept & multi;

  assign sum = data1 + data2;
  assign dif = data1 - data2;

  // Single-cycle result; unchanged ops pass the stored flags through.
  always_comb begin
    sc_res  = '0;
    sc_tgt  = '0;
    sc_zero = 1'b0;
    sc_fl   = flags;
    ovf     = 1'b0;
    go_mul  = 1'b0;
`ifdef ALU_SEQ_DIV_EN
    go_div  = 1'b0;
`endif
    case (alu_op)
      OP_NOP:  ;
      OP_LW_1: sc_res = sum;
      OP_LW_2, OP_LW_3, OP_SW_2: sc_res = data1;
      OP_SW_1: sc_res = data1 + WIDTH'(8);
      OP_MOV:  sc_res = WIDTH'({data1[4:0], data2[4:0]});
      OP_ADD, OP_SUB: begin
        if (alu_op == OP_ADD) begin
          sc_res = sum;
          ovf    = (data1[WIDTH-1] == data2[WIDTH-1]) & (sum[WIDTH-1] != data1[WIDTH-1]);
        end else begin
          sc_res = dif;
          ovf    = (data1[WIDTH-1] != data2[WIDTH-1]) & (dif[WIDTH-1] != data1[WIDTH-1]);
        end
        sc_fl           = '0;
        sc_fl[FL_OVF]   = ovf;
        sc_fl[FL_ERROR] = ovf;
        sc_zero         = (sc_res == '0);
      end
      OP_MUL: go_mul = 1'b1;
      OP_DIV: begin
`ifdef ALU_SEQ_DIV_EN
        go_div = (data2 != '0);
`endif
        // divide-by-zero (or no divider): immediate error result
        sc_fl           = '0;
        sc_fl[FL_ERROR] = 1'b1;
        sc_zero         = 1'b1;
      end
      OP_AND: begin sc_res = data1 & data2; sc_zero = (sc_res == '0); end
      OP_OR:  begin sc_res = data1 | data2; sc_zero = (sc_res == '0); end
      OP_NOT: sc_res = ~data1;
      OP_SHL: sc_res = (data2 >= WIDTH'(WIDTH)) ? '0 : (data1 << data2);
      OP_SHR: sc_res = (data2 >= WIDTH'(WIDTH)) ? '0 : (data1 >> data2);
      OP_CMP: begin
        sc_fl           = '0;
        sc_fl[FL_EQUAL] = (data1 == data2);
        sc_fl[FL_ABOVE] = ($signed(data1) > $signed(data2));
        sc_fl[FL_BELOW] = ($signed(data1) < $signed(data2));
      end
      OP_JR, OP_RET: begin sc_tgt = data1; sc_zero = 1'b1; end
      OP_JPC:  begin sc_tgt = WIDTH'(pc) + data2; sc_zero = 1'b1; end
      OP_CALL: begin sc_res = data1; sc_zero = 1'b1; end
      OP_BRFL: if (flags == data2[4:0]) begin sc_res = data1; sc_zero = 1'b1; end
      default: begin
        sc_fl           = '0;
        sc_fl[FL_ERROR] = 1'b1;
      end
    endcase
`ifdef ALU_SEQ_DIV_EN
    multi = go_mul | go_div;
`else
    multi = go_mul;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_nx = go_mul ? S_MUL : (multi ? S_DIV : S_DONE);
        else if (state == S_DONE && out_ready) state_nx = S_IDLE;
      end
      S_MUL, S_DIV: if (md_done) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_result    <= '0;
      branch_target <= '0;
      zero          <= 1'b0;
      flags         <= '0;
    end else if (accept && !multi) begin
      alu_result    <= sc_res;
      branch_target <= sc_tgt;
      zero          <= sc_zero;
      flags         <= sc_fl;
    end else if (md_done) begin
      alu_result    <= md_res;
      branch_target <= '0;
      zero          <= (md_res == '0);
      flags         <= (state == S_MUL) ? {md_ovf, 3'b000, md_ovf} : 5'b00000;
    end
  end

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
`ifdef ALU_SEQ_DIV_EN
    .is_div (go_div),
`endif
    .a      (data1),
    .b      (data2),
    .done   (md_done),
    .result (md_res),
    .ovf    (md_ovf)
  );

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the execute-stage ALU. Accepts one operation per transaction over a valid/ready interface and completes single-cycle ops in one clock. Multiply and divide run as iterative multi-cycle operations. Holds a persistent flags register so `BRFL` tests the flags of the last flag-setting instruction. Sits in EX between the ID/EX register and the EX/MEM register.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width (≥8, power of two)
- `PC_WIDTH`, 8, program-counter width (≤ WIDTH)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  operation offered
- `in_ready`  out  1  block can accept an operation
- `alu_op`  in  5  opcode; same encoding as the existing ALU control field
- `data1`, `data2`  in  WIDTH  signed operands
- `pc`  in  PC_WIDTH  PC of the instruction
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer takes result
- `alu_result`  out  WIDTH  signed result
- `branch_target`  out  WIDTH  jump address
- `zero`  out  1  zero/branch-taken indication
- `flags`  out  5  stored flags: [0] overflow, [1] above, [2] below, [3] equal, [4] error

## Operation
- States: IDLE, MUL, DIV, DONE.
- `in_ready` = (state==IDLE) | (state==DONE & out_ready).
- Accept occurs when `in_valid & in_ready`. Operands and opcode are latched on acceptance.
- Single-cycle ops go to DONE. MUL and DIV go to MUL/DIV for WIDTH iterations, then to DONE.
- DONE holds `out_valid` and all result outputs stable until `out_ready`. It then goes to IDLE, or directly to a new op if one is accepted in the same cycle.
- Ops:
  - LW_1: d1+d2.
  - LW_2, LW_3, SW_2: d1.
  - SW_1: d1+8.
  - MOV: zero-extended {d1[4:0],d2[4:0]}.
  - ADD, SUB: signed overflow sets overflow and error.
  - MUL: signed shift-add into a 2·WIDTH product. Result is the low WIDTH bits. Overflow and error are set when the high half ≠ sign-extension of the low half.
  - DIV: signed restoring division, truncating toward zero. d2==0 gives result 0 with error set, in 1 cycle (no iteration).
  - AND, OR, NOT: bitwise.
  - SHL, SHR: logical shift of d1 by d2. Any shift amount ≥ WIDTH gives 0.
  - CMP: signed compare sets exactly one of equal/above/below.
  - JR, RET: `branch_target`=d1, zero=1.
  - JPC: `branch_target`=zero-extended pc + d2, modulo 2^WIDTH; zero=1.
  - CALL: result d1, zero=1.
  - BRFL: zero=1 and result=d1 iff `flags`==d2[4:0]; otherwise zero=0 and result=0.
  - NOP: all zero.
  - Undefined opcode: result 0, error set.
- `zero` for ADD/SUB/MUL/DIV/AND/OR = (result==0). For other ops, as listed above.
- `flags` is rewritten (all five bits, cleared then set) when ADD, SUB, MUL, DIV, CMP or an undefined opcode completes. All other ops leave it unchanged.

## Timing
- Reset: state IDLE; `out_valid`, `alu_result`, `branch_target`, `zero`, `flags` all 0; `in_ready` 1 from the first cycle after reset.
- Latency is counted from the accept edge to the first cycle with `out_valid`=1:
  - Single-cycle ops: 1.
  - MUL: WIDTH+1.
  - DIV: WIDTH+2, including sign correction.
- Throughput is one single-cycle op per clock while `out_ready`=1.
- `rst_n` low during MUL/DIV or DONE aborts the op. The result is discarded and `flags` cleared on the next edge.
- `in_valid` ignored while `in_ready`=0; operands need not be held after accept.

## Configuration
- `ALU_SEQ_DIV_EN` defined: iterative divider present; DIV as above.
- Undefined: no divider logic. DIV completes in 1 cycle with result 0, zero=1, and error flag set, for every operand pair.

## Structure
- Package `alu_pkg`: opcode localparams, flag bit indices, state enum.
- One sub-module `alu_seq_muldiv`: shared iterative multiply/divide datapath with start/done and an iteration counter. It is instantiated once and the FSM drives it.

## Test plan
- ADD 0x7FFFFFFF+1 -> result 0x80000000, flags=5'b10001, out_valid after 1 cycle.
- CMP 5,5 then BRFL d1=0x40 d2=5'b01000 -> zero=1, result 0x40. The following BRFL with d2=5'b00010 -> zero=0, result 0.
- MUL 0x00010000×0x00010000 (WIDTH=32) -> result 0, overflow+error set, out_valid after exactly 33 cycles. MUL −3×7 -> −21, flags 0.
- DIV −7/2 -> −3. DIV 9/0 -> result 0, error=1, 1-cycle latency. Repeat the 9/0 case with the macro undefined.
- Back-to-back ADD/AND/OR with `out_ready`=1 -> one result per clock. Hold `out_ready`=0 -> outputs stable, `in_ready`=0.
- Assert `rst_n`=0 mid-MUL -> next edge: IDLE, out_valid=0, flags=0. A new op is accepted immediately after reset releases.
